w_r16_wr_arbiter: RTL and testbench

Round-robin write scheduler for one SRAM bank write port shared by 16 requesters. It drives `sel_in` and `w_enable` of the bank's 16:1 write-input mux, which then produces CEN/WEN/A/D. Each requester asks for a burst of 1-16 consecutive write beats. A granted burst is never interrupted by another requester, and ownership passes between requesters without idle cycles.

---
 rtl/w_R16_arb_pkg.sv | 18 +
 rtl/w_R16_rr_pick.sv | 35 +++
 rtl/w_r16_wr_arbiter.sv | 97 +++++++++
 tb/tb_w_r16_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/w_R16_arb_pkg.sv
// Shared types and sizes for the 16-requester SRAM write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package w_R16_arb_pkg;

    localparam int NUM_REQ = 16;  // downstream write mux is 16:1
    localparam int SEL_W   = 4;
    localparam int LEN_W   = 4;   // field holds beats-1, so bursts are 1..16 beats

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [LEN_W-1:0] len_t;

endpackage

// File: rtl/w_R16_rr_pick.sv
// Round-robin pick: first set request at or after start, wrapping 15 -> 0.
// Latency: purely combinational.
// Backpressure: none; valid is simply |req.
module w_R16_rr_pick
    import w_R16_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  sel_t               start,
    output logic               valid,
    output sel_t               idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    sel_t                 enc;

    // Rotate so that requester 'start' lands at bit 0.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[start +: NUM_REQ];
    assign valid   = |req;

    // Priority-encode the rotated vector: lowest set bit wins.
    always_comb begin
        enc = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                enc = sel_t'(i);
            end
        end
    end

    // Un-rotate; the 4-bit add wraps modulo 16.
    assign idx = enc + start;

endmodule

// File: rtl/w_r16_wr_arbiter.sv
// Round-robin burst write scheduler for one SRAM bank port shared by 16 requesters.
// Latency: req seen at edge N -> first grant beat in the cycle after edge N; zero-bubble handoff.
// Backpressure: stall blocks arbitration and beat issue, bursts hold position; flush aborts to IDLE.
module w_r16_wr_arbiter
    import w_R16_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic                     stall,
    input  logic                     flush,
    output logic [SEL_W-1:0]         sel_out,
    output logic                     w_enable_out,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     last_beat,
    output logic                     busy
);

    arb_state_t state_q, state_d;
    sel_t       owner_q, owner_d;
    sel_t       ptr_q,   ptr_d;
    len_t       cnt_q,   cnt_d;

    sel_t       pick_start;
    logic       pick_vld;
    sel_t       pick_idx;
    len_t       pick_len;
    logic       beat;

    // One picker serves both paths: from ptr in IDLE, from owner+1 on release.
    assign pick_start = (state_q == BURST) ? sel_t'(owner_q + 4'd1) : ptr_q;

    w_R16_rr_pick u_pick (
        .req   (req),
        .start (pick_start),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign pick_len = req_len[{pick_idx, 2'b00} +: LEN_W];

    // Output decode straight from the registers and stall.
    assign beat         = (state_q == BURST) && !stall;
    assign w_enable_out = beat;
    assign sel_out      = owner_q;
    assign gnt          = beat ? (NUM_REQ'(1) << owner_q) : '0;
    assign last_beat    = beat && (cnt_q == '0);
    assign busy         = (state_q == BURST);

    // Next-state: flush beats everything, then arbitration / beat counting.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (pick_vld && !stall) begin
                owner_d = pick_idx;
                cnt_d   = pick_len;
                state_d = BURST;
            end
        end else if (beat) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                // Release: the current owner's req still competes, but last in line.
                ptr_d = sel_t'(owner_q + 4'd1);
                if (pick_vld) begin
                    owner_d = pick_idx;
                    cnt_d   = pick_len;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    // State registers with asynchronous reset; remaining beats are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_w_r16_wr_arbiter.sv
// Bench for the 16-way burst write arbiter: directed scenarios plus random traffic.
// Latency: one check point per clock, on the falling edge.
// Backpressure: stall and flush driven both directed and at random.
module tb_w_r16_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic [63:0] req_len = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  sel_out;
    logic        w_enable_out;
    logic [15:0] gnt;
    logic        last_beat;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: burst-level view (who owns the port, beats still to go).
    bit m_busy;
    int m_owner;
    int m_left;
    int m_ptr;

    // Outputs seen at the most recent check point.
    logic [15:0] o_gnt;
    logic [3:0]  o_sel;
    logic        o_wen;
    logic        o_last;
    logic        o_busy;

    always #5 clk = ~clk;

    w_r16_wr_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_len      (req_len),
        .stall        (stall),
        .flush        (flush),
        .sel_out      (sel_out),
        .w_enable_out (w_enable_out),
        .gnt          (gnt),
        .last_beat    (last_beat),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [15:0] r, input int start);
        for (int k = 0; k < 16; k++) begin
            if (r[(start + k) % 16]) return (start + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_left  = 0;
        m_ptr   = 0;
    endtask

    task automatic model_take(input int w);
        m_owner = w;
        m_left  = int'(req_len[4*w +: 4]) + 1;
        m_busy  = 1'b1;
    endtask

    task automatic model_update();
        int w;
        if (rst) begin
            model_reset();
        end else if (flush) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (req != 0 && !stall) model_take(rr(req, m_ptr));
        end else if (!stall) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                m_ptr = (m_owner + 1) % 16;
                w = rr(req, m_ptr);
                if (w >= 0) model_take(w);
                else m_busy = 1'b0;
            end
        end
    endtask

    // One clock: compare outputs at the falling edge, then advance the model.
    task automatic step();
        logic        ew;
        logic [15:0] eg;
        if (rst) model_reset();
        @(negedge clk);
        ew = m_busy && !stall;
        eg = ew ? (16'd1 << m_owner) : 16'd0;
        o_gnt = gnt; o_sel = sel_out; o_wen = w_enable_out; o_last = last_beat; o_busy = busy;
        check("w_enable", w_enable_out, ew);
        check("gnt", gnt, eg);
        check("last_beat", last_beat, ew && (m_left == 1));
        check("busy", busy, m_busy);
        check("gnt_onehot0", $onehot0(gnt), 1);
        if (m_busy) check("sel_out", sel_out, m_owner);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_len = '0; stall = 1'b0; flush = 1'b0;
        step();
        check("rst_sel", o_sel, 0);
        check("rst_wen", o_wen, 0);
        check("rst_gnt", o_gnt, 0);
        check("rst_last", o_last, 0);
        check("rst_busy", o_busy, 0);
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        req = '0; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < n; i++) step();
        check("drain_idle", o_busy, 0);
    endtask

    initial begin
        int pulses;
        int lasts;
        logic [31:0] r0;
        logic [31:0] r1;

        // Single 3-beat burst from requester 0.
        do_reset();
        req = 16'h0001;
        req_len[3:0] = 4'd2;
        step();
        req = '0;
        pulses = 0; lasts = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_gnt == 16'h0001) pulses++;
            if (o_last) lasts++;
            if (i == 2) check("t1_last_on_third", o_last, 1);
        end
        check("t1_pulses", pulses, 3);
        check("t1_lasts", lasts, 1);
        check("t1_idle", o_busy, 0);

        // Zero-bubble alternation between 0 and 15 across the wrap.
        do_reset();
        req = 16'h8001;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_wen", o_wen, 1);
            check("t2_owner", o_sel, (i % 2 == 0) ? 0 : 15);
        end
        drain(3);

        // Stall in the middle of a 4-beat burst from requester 5.
        do_reset();
        req = 16'h0020;
        req_len[23:20] = 4'd3;
        step();
        req = '0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            stall = (i == 2 || i == 3);
            step();
            if (i < 6) check("t3_sel_hold", o_sel, 5);
            if (o_gnt != 0) pulses++;
        end
        stall = 1'b0;
        check("t3_pulses", pulses, 4);
        check("t3_idle", o_busy, 0);

        // Flush on beat 2 of an 8-beat burst from requester 7, then re-grant.
        do_reset();
        req = 16'h0080;
        req_len[31:28] = 4'd7;
        step();
        step();
        flush = 1'b1;
        step();
        check("t4_flush_beat", o_wen, 1);
        check("t4_flush_sel", o_sel, 7);
        flush = 1'b0;
        req_len[31:28] = 4'd2;
        step();
        check("t4_after_flush_idle", o_busy, 0);
        req = '0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_gnt == 16'h0080) pulses++;
        end
        check("t4_regrant_pulses", pulses, 3);

        // All requesters, single beats: strict 0..15 rotation twice.
        do_reset();
        req = 16'hFFFF;
        step();
        for (int i = 0; i < 32; i++) begin
            step();
            check("t5_gnt", o_gnt, 32'd1 << (i % 16));
            check("t5_sel", o_sel, i % 16);
        end
        drain(3);

        // Stall held from reset keeps everything idle.
        rst = 1'b1; stall = 1'b1; req = 16'hFFFF;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_gnt_quiet", o_gnt, 0);
            check("t6_busy_quiet", o_busy, 0);
        end
        stall = 1'b0;
        step();
        step();
        check("t6_first_gnt", o_gnt, 16'h0001);
        drain(3);

        // Random traffic, including async reset and flush at arbitrary points.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r0 = $urandom();
            r1 = $urandom();
            req     = r0[15:0] & r0[31:16] & (($urandom_range(0, 3) == 0) ? 16'hFFFF : r1[15:0]);
            req_len = {r1 & 32'h3333_3333, $urandom()};
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 29) == 0);
            rst     = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
